// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the TxCore front end and the UART framing stage.
interface uart_tx_serializer_if;
   logic [7:0] TxData_i;
   logic       TxValid_i;
   logic       TxReady_o;
   logic       ParityEnable_i;
   logic       TwoStop_i;

   modport master (
      output TxData_i, TxValid_i, ParityEnable_i, TwoStop_i,
      input  TxReady_o
   );

   modport slave (
      input  TxData_i, TxValid_i, ParityEnable_i, TwoStop_i,
      output TxReady_o
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit framing: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, all paced by the baud-generator pulse.
module uart_tx_serializer #(
   parameter int MIN_IDLE_BAUDS = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        p_BaudSig_i,
   uart_tx_serializer_if.slave         tx_if,
   input  logic                        ParityResult_i,
   output logic [4:0]                  State_o,
   output logic                        p_ParityCalTrigger_o,
   output logic [7:0]                  Data_o,
   output logic [3:0]                  BitCounter_o,
   output logic                        Tx_o,
   output logic                        p_TxDone_o
);

   typedef enum logic [4:0] {
      INTERVAL  = 5'b00001,
      STARTBIT  = 5'b00010,
      DATABITS  = 5'b00100,
      PARITYBIT = 5'b01000,
      STOPBIT   = 5'b10000
   } state_t;

   state_t     state;
   logic [7:0] shift_q;
   logic       par_en_q;
   logic       two_stop_q;
   logic       pending;
   logic       tx_ready;
   // Idle baud periods still owed before the next start bit; zero after reset
   // so the first frame is not held back.
   logic [3:0] idle_left;
   logic       accept;

   assign accept          = tx_if.TxValid_i & tx_ready;
   assign tx_if.TxReady_o = tx_ready;
   assign State_o         = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= INTERVAL;
         shift_q              <= 8'd0;
         par_en_q             <= 1'b0;
         two_stop_q           <= 1'b0;
         pending              <= 1'b0;
         tx_ready             <= 1'b0;
         idle_left            <= 4'd0;
         p_ParityCalTrigger_o <= 1'b0;
         Data_o               <= 8'd0;
         BitCounter_o         <= 4'd0;
         Tx_o                 <= 1'b1;
         p_TxDone_o           <= 1'b0;
      end else begin
         p_ParityCalTrigger_o <= 1'b0;
         p_TxDone_o           <= 1'b0;
         case (state)
            INTERVAL: begin
               Tx_o <= 1'b1;
               if (accept) begin
                  Data_o     <= tx_if.TxData_i;
                  shift_q    <= tx_if.TxData_i;
                  par_en_q   <= tx_if.ParityEnable_i;
                  two_stop_q <= tx_if.TwoStop_i;
                  pending    <= 1'b1;
                  tx_ready   <= 1'b0;
               end else begin
                  tx_ready <= ~pending;
               end
               // accept implies pending was clear, so a same-cycle pulse cannot start the frame
               if (p_BaudSig_i) begin
                  if (pending && idle_left == 4'd0) begin
                     state        <= STARTBIT;
                     Tx_o         <= 1'b0;
                     BitCounter_o <= 4'd0;
                  end else if (idle_left != 4'd0) begin
                     idle_left <= idle_left - 4'd1;
                  end
               end
            end
            STARTBIT: begin
               if (p_BaudSig_i) begin
                  state        <= DATABITS;
                  Tx_o         <= shift_q[0];
                  shift_q      <= shift_q >> 1;
                  BitCounter_o <= 4'd0;
               end
            end
            DATABITS: begin
               if (p_BaudSig_i) begin
                  if (BitCounter_o == 4'd7) begin
                     BitCounter_o <= 4'd0;
                     if (par_en_q) begin
                        state <= PARITYBIT;
                        Tx_o  <= ParityResult_i;
                     end else begin
                        state <= STOPBIT;
                        Tx_o  <= 1'b1;
                     end
                  end else begin
                     Tx_o                 <= shift_q[0];
                     shift_q              <= shift_q >> 1;
                     BitCounter_o         <= BitCounter_o + 4'd1;
                     p_ParityCalTrigger_o <= par_en_q && (BitCounter_o == 4'd0);
                  end
               end
            end
            PARITYBIT: begin
               if (p_BaudSig_i) begin
                  state        <= STOPBIT;
                  Tx_o         <= 1'b1;
                  BitCounter_o <= 4'd0;
               end
            end
            STOPBIT: begin
               if (p_BaudSig_i) begin
                  if (two_stop_q && BitCounter_o == 4'd0) begin
                     BitCounter_o <= 4'd1;
                  end else begin
                     state        <= INTERVAL;
                     BitCounter_o <= 4'd0;
                     pending      <= 1'b0;
                     idle_left    <= 4'(MIN_IDLE_BAUDS);
                     p_TxDone_o   <= 1'b1;
                     tx_ready     <= 1'b1;
                  end
               end
            end
            default: begin
               state        <= INTERVAL;
               Tx_o         <= 1'b1;
               BitCounter_o <= 4'd0;
               pending      <= 1'b0;
               tx_ready     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for the UART transmit framing stage.
module tb_uart_tx_serializer;

   localparam logic [4:0] S_INT = 5'b00001;
   localparam logic [4:0] S_STA = 5'b00010;
   localparam logic [4:0] S_DAT = 5'b00100;
   localparam logic [4:0] S_PAR = 5'b01000;
   localparam logic [4:0] S_STP = 5'b10000;

   logic       clk;
   logic       rst;
   logic       p_BaudSig_i;
   logic       ParityResult_i;
   logic [4:0] State_o;
   logic       p_ParityCalTrigger_o;
   logic [7:0] Data_o;
   logic [3:0] BitCounter_o;
   logic       Tx_o;
   logic       p_TxDone_o;

   uart_tx_serializer_if tx_if ();

   uart_tx_serializer #(.MIN_IDLE_BAUDS(1)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .p_BaudSig_i          (p_BaudSig_i),
      .tx_if                (tx_if),
      .ParityResult_i       (ParityResult_i),
      .State_o              (State_o),
      .p_ParityCalTrigger_o (p_ParityCalTrigger_o),
      .Data_o               (Data_o),
      .BitCounter_o         (BitCounter_o),
      .Tx_o                 (Tx_o),
      .p_TxDone_o           (p_TxDone_o)
   );

   // Even-parity generator holding its result from the latched byte
   assign ParityResult_i = ^Data_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int trig_cnt = 0;
   int done_cnt = 0;
   int acc_cnt  = 0;
   int par_cyc  = 0;
   logic trig_after;

   always @(negedge clk) begin
      if (p_ParityCalTrigger_o === 1'b1) trig_cnt++;
      if (p_TxDone_o === 1'b1) done_cnt++;
      if (tx_if.TxValid_i === 1'b1 && tx_if.TxReady_o === 1'b1) acc_cnt++;
      if (State_o === S_PAR) par_cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic baud();
      p_BaudSig_i = 1'b1;
      tick();
      trig_after  = p_ParityCalTrigger_o;
      p_BaudSig_i = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_accept(input logic [7:0] d, input logic par, input logic two, input logic keep);
      tx_if.TxData_i       = d;
      tx_if.ParityEnable_i = par;
      tx_if.TwoStop_i      = two;
      tx_if.TxValid_i      = 1'b1;
      for (int k = 0; k < 100 && tx_if.TxReady_o !== 1'b1; k++) tick();
      chk("accept_wait", tx_if.TxReady_o, 1);
      tick();
      if (!keep) tx_if.TxValid_i = 1'b0;
      chk("accept_ready_drop", tx_if.TxReady_o, 0);
      chk("accept_data", Data_o, d);
   endtask

   task automatic run_bits(input logic [7:0] d, input logic par, input logic two, input int idle);
      int t0, d0, p0;
      t0 = trig_cnt;
      d0 = done_cnt;
      p0 = par_cyc;
      for (int i = 0; i < idle; i++) begin
         baud();
         chk("idle_state", State_o, S_INT);
         chk("idle_tx", Tx_o, 1);
      end
      baud();
      chk("start_state", State_o, S_STA);
      chk("start_tx", Tx_o, 0);
      chk("start_ready", tx_if.TxReady_o, 0);
      for (int i = 0; i < 8; i++) begin
         baud();
         chk("data_state", State_o, S_DAT);
         chk("data_tx", Tx_o, d[i]);
         chk("data_cnt", BitCounter_o, i);
         if (i == 1) chk("trig_bit1", trig_after, par);
      end
      if (par) begin
         baud();
         chk("par_state", State_o, S_PAR);
         chk("par_tx", Tx_o, ^d);
      end
      baud();
      chk("stop_state", State_o, S_STP);
      chk("stop_tx", Tx_o, 1);
      chk("stop_ready", tx_if.TxReady_o, 0);
      chk("stop_data_hold", Data_o, d);
      chk("stop_no_done", done_cnt, d0);
      if (two) begin
         baud();
         chk("stop2_state", State_o, S_STP);
         chk("stop2_cnt", BitCounter_o, 1);
         chk("stop2_tx", Tx_o, 1);
         chk("stop2_no_done", done_cnt, d0);
      end
      baud();
      chk("done_pulse", done_cnt, d0 + 1);
      chk("done_state", State_o, S_INT);
      chk("done_tx", Tx_o, 1);
      chk("trig_count", trig_cnt - t0, par);
      chk("par_state_seen", par_cyc != p0, par);
      if (!tx_if.TxValid_i) chk("done_ready", tx_if.TxReady_o, 1);
   endtask

   initial begin
      int acc0;
      rst                  = 1'b1;
      p_BaudSig_i          = 1'b0;
      tx_if.TxData_i       = 8'd0;
      tx_if.TxValid_i      = 1'b0;
      tx_if.ParityEnable_i = 1'b0;
      tx_if.TwoStop_i      = 1'b0;
      trig_after           = 1'b0;
      #1;
      chk("rst_tx", Tx_o, 1);
      chk("rst_state", State_o, S_INT);
      chk("rst_ready", tx_if.TxReady_o, 0);
      chk("rst_data", Data_o, 0);
      chk("rst_cnt", BitCounter_o, 0);
      chk("rst_trig", p_ParityCalTrigger_o, 0);
      chk("rst_done", p_TxDone_o, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("ready_after_rst", tx_if.TxReady_o, 1);

      // T2: 0x35 with even parity, first frame after reset
      do_accept(8'h35, 1'b1, 1'b0, 1'b0);
      run_bits(8'h35, 1'b1, 1'b0, 0);

      // T3: 0xFF, no parity, two stop bits, one idle period owed
      do_accept(8'hFF, 1'b0, 1'b1, 1'b0);
      run_bits(8'hFF, 1'b0, 1'b1, 1);

      // Pay off the idle period with nothing pending
      baud();
      chk("idle_no_start", State_o, S_INT);

      // T5: accept and baud pulse on the same edge
      chk("t5_ready", tx_if.TxReady_o, 1);
      tx_if.TxData_i       = 8'h5A;
      tx_if.ParityEnable_i = 1'b0;
      tx_if.TwoStop_i      = 1'b0;
      tx_if.TxValid_i      = 1'b1;
      p_BaudSig_i          = 1'b1;
      tick();
      p_BaudSig_i     = 1'b0;
      tx_if.TxValid_i = 1'b0;
      chk("t5_state", State_o, S_INT);
      chk("t5_tx", Tx_o, 1);
      chk("t5_data", Data_o, 8'h5A);
      chk("t5_ready_drop", tx_if.TxReady_o, 0);
      repeat (2) tick();
      run_bits(8'h5A, 1'b0, 1'b0, 0);

      // T6: inputs change mid-frame; odd-weight byte gives parity 1
      do_accept(8'h07, 1'b1, 1'b0, 1'b0);
      tx_if.TxData_i       = 8'hAA;
      tx_if.ParityEnable_i = 1'b0;
      tx_if.TwoStop_i      = 1'b1;
      run_bits(8'h07, 1'b1, 1'b0, 1);

      // T4: TxValid held across three frames
      acc0 = acc_cnt;
      do_accept(8'h12, 1'b0, 1'b0, 1'b1);
      tx_if.TxData_i       = 8'h34;
      tx_if.ParityEnable_i = 1'b0;
      tx_if.TwoStop_i      = 1'b0;
      run_bits(8'h12, 1'b0, 1'b0, 1);
      chk("t4_second_latched", Data_o, 8'h34);
      tx_if.TxData_i = 8'h56;
      run_bits(8'h34, 1'b0, 1'b0, 1);
      chk("t4_third_latched", Data_o, 8'h56);
      tx_if.TxValid_i = 1'b0;
      run_bits(8'h56, 1'b0, 1'b0, 1);
      chk("t4_accepts", acc_cnt - acc0, 3);

      // T1: reset in the middle of the data bits
      do_accept(8'hC3, 1'b1, 1'b0, 1'b0);
      baud();
      baud();
      baud();
      chk("t1_pre_state", State_o, S_DAT);
      rst = 1'b1;
      #1;
      chk("t1_tx", Tx_o, 1);
      chk("t1_state", State_o, S_INT);
      chk("t1_data", Data_o, 0);
      chk("t1_cnt", BitCounter_o, 0);
      chk("t1_ready_in_rst", tx_if.TxReady_o, 0);
      #1;
      rst = 1'b0;
      tick();
      chk("t1_ready", tx_if.TxReady_o, 1);

      // First frame after reset starts on the very next pulse
      do_accept(8'h81, 1'b0, 1'b0, 1'b0);
      run_bits(8'h81, 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
